// File: rtl/mdu_ctrl_pkg.sv
// Shared types and helpers for the multiply/divide unit controller.
package mdu_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ACC_W  = 64;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } mdu_res_t;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
      return neg ? (~x + DATA_W'(1)) : x;
   endfunction

   // Turns the unsigned magnitude result into the architectural HI/LO pair.
   function automatic mdu_res_t fixup(input logic [ACC_W-1:0] raw, input logic div,
                                      input logic neg_q, input logic neg_r, input logic div0);
      mdu_res_t r;
      logic [ACC_W-1:0] p;
      p = neg_q ? (~raw + ACC_W'(1)) : raw;
      r.hi = p[ACC_W-1:DATA_W];
      r.lo = p[DATA_W-1:0];
      if (div) begin
         r.lo = div0 ? '1 : cond_neg(raw[DATA_W-1:0], neg_q);
         r.hi = cond_neg(raw[ACC_W-1:DATA_W], neg_r);
      end
      return r;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iteration datapath: one shift-add multiply or restoring divide step per cycle
// on a 64-bit accumulator ({hi, lo} for multiply, {remainder, quotient} for divide).
module mdu_iter
   import mdu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              div,
   input  logic [ACC_W-1:0]  init,
   input  logic [DATA_W-1:0] opnd,
   output logic [ACC_W-1:0]  acc_nxt_c
);

   logic [ACC_W-1:0]  acc;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] rem;
   logic              qbit;

   // Borrow out of the 33-bit trial subtract means the shifted remainder is below the divisor.
   always_comb begin
      sum       = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      trial     = acc[ACC_W-1:DATA_W-1] - {1'b0, opnd};
      qbit      = ~trial[DATA_W];
      rem       = qbit ? trial[DATA_W-1:0] : acc[ACC_W-2:DATA_W-1];
      acc_nxt_c = {sum, acc[DATA_W-1:1]};
      if (div) begin
         acc_nxt_c = {rem, acc[DATA_W-2:0], qbit};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (load) begin
         acc <= init;
      end else if (step) begin
         acc <= acc_nxt_c;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller: FSM, operand sign handling, iteration
// counter and pipeline stall request around the mdu_iter datapath.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   output logic        stallreq_for_ex,
   output logic        result_valid,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic              div_q;
   logic              neg_q;
   logic              neg_r;
   logic              div0_q;
   logic [DATA_W-1:0] opnd_q;

   op_e               op_sel;
   logic              sgn_op;
   logic              div_op;
   logic              a_neg;
   logic              b_neg;
   logic              accept;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [ACC_W-1:0]  init;
   logic [ACC_W-1:0]  acc_nxt_c;
   mdu_res_t          res;

   always_comb begin
      op_sel = op_e'(op);
      sgn_op = (op_sel == OP_MULT) || (op_sel == OP_DIV);
      div_op = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
      a_neg  = sgn_op & src_a[DATA_W-1];
      b_neg  = sgn_op & src_b[DATA_W-1];
      a_mag  = cond_neg(src_a, a_neg);
      b_mag  = cond_neg(src_b, b_neg);
      init   = {DATA_W'(0), (div_op ? a_mag : b_mag)};
      accept = ~rst & ~cancel & start & (state == ST_IDLE);
      res    = fixup(acc_nxt_c, div_q, neg_q, neg_r, div0_q);
   end

   assign stallreq_for_ex = accept | (~rst & (state == ST_RUN));

   mdu_iter u_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .step      (state == ST_RUN),
      .div       (div_q),
      .init      (init),
      .opnd      (opnd_q),
      .acc_nxt_c (acc_nxt_c)
   );

   // Sign fix-up is folded into the RUN->DONE edge so hi_o/lo_o are stable for all of DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         result_valid <= 1'b0;
         hi_o         <= '0;
         lo_o         <= '0;
         div_q        <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div0_q       <= 1'b0;
         opnd_q       <= '0;
      end else begin
         result_valid <= 1'b0;
         if (cancel) begin
            state <= ST_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     div_q  <= div_op;
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     div0_q <= div_op & (src_b == '0);
                     opnd_q <= div_op ? b_mag : a_mag;
                     cnt    <= '0;
                     state  <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (cnt == CNT_W'(ITER - 1)) begin
                     state        <= ST_DONE;
                     cnt          <= '0;
                     result_valid <= 1'b1;
                     hi_o         <= res.hi;
                     lo_o         <= res.lo;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, random ops against a behavioural
// model, and hand-written cancel / back-to-back / reset sequences.
module tb_mdu_ctrl;

   localparam int unsigned ITER = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        stallreq_for_ex;
   logic        result_valid;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int          cyc    = 0;
   logic [63:0] sb_q[$];
   int          strobe_cyc[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[13];

   mdu_ctrl #(.ITER(ITER)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op              (op),
      .src_a           (src_a),
      .src_b           (src_b),
      .cancel          (cancel),
      .stallreq_for_ex (stallreq_for_ex),
      .result_valid    (result_valid),
      .hi_o            (hi_o),
      .lo_o            (lo_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", nm, act, exp);
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Scoreboard: every strobe pops the oldest expected {hi, lo}.
   initial begin
      logic [63:0] e;
      forever begin
         @(posedge clk); #1;
         if (result_valid === 1'b1) begin
            strobe_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
               chk("unexpected_strobe", {63'd0, result_valid}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("result", {hi_o, lo_o}, e);
            end
         end
      end
   end

   // Call just after a rising edge with the DUT idle.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string nm);
      int n;
      int stall_bad;
      op = o; src_a = a; src_b = b; start = 1'b1;
      #1 chk({nm, "_stall_idle"}, 64'(stallreq_for_ex), 64'd1);
      sb_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      stall_bad = 0;
      while (result_valid !== 1'b1 && n < 2 * ITER) begin
         if (stallreq_for_ex !== 1'b1) stall_bad++;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, 64'(n + 1), 64'(ITER + 1));
      chk({nm, "_stall_run"}, 64'(stall_bad), 64'd0);
      chk({nm, "_stall_done"}, 64'(stallreq_for_ex), 64'd0);
      @(posedge clk); #1;
      chk({nm, "_strobe_width"}, 64'(result_valid), 64'd0);
      chk({nm, "_hold"}, {hi_o, lo_o}, exp);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   initial begin
      int          n0;
      int          n;
      int          diff;
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;

      vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
      vecs[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF};
      vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
      vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
      vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[7]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF};
      vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
      vecs[9]  = '{2'b01, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000};
      vecs[10] = '{2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[11] = '{2'b10, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E};
      vecs[12] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      #1;
      chk("reset_stall", 64'(stallreq_for_ex), 64'd0);
      chk("reset_valid", 64'(result_valid), 64'd0);
      chk("reset_hilo", {hi_o, lo_o}, 64'd0);
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_stall", 64'(stallreq_for_ex), 64'd0);

      for (int i = 0; i < 13; i++)
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 10; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
         do_op(o, a, b, model(o, a, b), $sformatf("rand%0d", i));
      end

      // Cancel in the middle of RUN, then a fresh operation.
      n0 = strobe_cyc.size();
      op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("cancel_run_stall", 64'(stallreq_for_ex), 64'd1);
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cancel_stall", 64'(stallreq_for_ex), 64'd0);
      chk("cancel_valid", 64'(result_valid), 64'd0);
      repeat (2 * ITER) @(posedge clk);
      #1;
      chk("cancel_no_strobe", 64'(strobe_cyc.size()), 64'(n0));
      do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, "after_cancel");

      // Cancel beats start in IDLE.
      n0 = strobe_cyc.size();
      start = 1'b1; cancel = 1'b1;
      #1 chk("cancel_prio_stall", 64'(stallreq_for_ex), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      #1 chk("cancel_prio_idle", 64'(stallreq_for_ex), 64'd0);
      repeat (ITER + 4) @(posedge clk);
      #1;
      chk("cancel_prio_no_strobe", 64'(strobe_cyc.size()), 64'(n0));

      // Start held through DONE, then back-to-back second operation.
      n0 = strobe_cyc.size();
      op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      sb_q.push_back(model(2'b11, 32'd1000, 32'd3));
      @(posedge clk); #1;
      n = 0;
      while (result_valid !== 1'b1 && n < 2 * ITER) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_done_stall", 64'(stallreq_for_ex), 64'd0);
      op = 2'b00; src_a = 32'hFFFF_FFF0; src_b = 32'd5;
      sb_q.push_back(model(2'b00, 32'hFFFF_FFF0, 32'd5));
      @(posedge clk); #1;
      chk("b2b_idle_stall", 64'(stallreq_for_ex), 64'd1);
      @(posedge clk); #1;
      n = 0;
      while (result_valid !== 1'b1 && n < 2 * ITER) begin
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_strobes", 64'(strobe_cyc.size()), 64'(n0 + 2));
      diff = (strobe_cyc.size() >= n0 + 2) ? strobe_cyc[n0 + 1] - strobe_cyc[n0] : -1;
      chk("b2b_spacing", 64'(diff), 64'(ITER + 2));

      // Reset in the middle of RUN discards the operation and clears outputs.
      n0 = strobe_cyc.size();
      op = 2'b10; src_a = 32'd77; src_b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1 chk("rst_run_stall_comb", 64'(stallreq_for_ex), 64'd0);
      @(posedge clk); #1;
      chk("rst_run_valid", 64'(result_valid), 64'd0);
      chk("rst_run_hilo", {hi_o, lo_o}, 64'd0);
      chk("rst_run_stall", 64'(stallreq_for_ex), 64'd0);
      rst = 1'b0; start = 1'b0;
      repeat (2 * ITER) @(posedge clk);
      #1;
      chk("rst_run_no_strobe", 64'(strobe_cyc.size()), 64'(n0));
      chk("rst_run_hilo_held", {hi_o, lo_o}, 64'd0);

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
